// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths, state vector type and FSM encoding for the iterative SubBytes stage
package aes_pkg;
   localparam int STATE_W = 128;
   localparam int BYTE_W  = 8;

   typedef logic [STATE_W-1:0] state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fsm_state_t;
endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - one-byte combinational FIPS-197 forward S-box
module aes_sbox
   import aes_pkg::*;
(
   input  logic [BYTE_W-1:0] in_i,
   output logic [BYTE_W-1:0] out_o
);
   // Entry for input 0x00 sits in the MSBs, so the lookup offset uses the inverted input.
   localparam logic [256*BYTE_W-1:0] TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] base;

   assign base  = {~in_i, 3'b000};
   assign out_o = TBL[base +: BYTE_W];
endmodule

// File: rtl/sub_bytes_iter.sv
// rtl/sub_bytes_iter.sv - iterative AES SubBytes, LANES bytes per cycle, valid/ready in and out
module sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] data_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] data_out,
   output logic               busy
);
   localparam int NCHUNK  = 16 / LANES;
   localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CHUNK_W = LANES * BYTE_W;

   fsm_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           work_q, work_d;

   logic [6:0]         off;
   logic [CHUNK_W-1:0] chunk_in;
   logic [CHUNK_W-1:0] chunk_out;

   // Chunk 0 is the most significant slice of the state.
   assign off      = 7'((NCHUNK - 1 - int'(cnt_q)) * CHUNK_W);
   assign chunk_in = work_q[off +: CHUNK_W];

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      aes_sbox u_sbox (
         .in_i  (chunk_in[g*BYTE_W +: BYTE_W]),
         .out_o (chunk_out[g*BYTE_W +: BYTE_W])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               work_d  = data_in;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            busy                  = 1'b1;
            work_d[off +: CHUNK_W] = chunk_out;
            if (cnt_q == CNT_W'(NCHUNK - 1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            // Emit and accept on the same edge keeps the pipe full.
            if (out_ready) begin
               if (in_valid) begin
                  work_d  = data_in;
                  cnt_d   = '0;
                  state_d = BUSY;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign data_out = work_q;
endmodule
